// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: valid/ready byte FIFO feeding a UART transmitter (8N1, LSB first).
// Optional feature macro UART_TX_PARITY_EN adds an even-parity bit, giving 8E1 frames.
module uart_tx_fifo #(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                         Clk,
    input  logic                         reset_rtl_0,
    input  logic [7:0]                   tx_data,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    output logic                         txd,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int unsigned DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned BW  = $clog2(DIV);

    localparam logic [BW-1:0] BaudLast  = BW'(DIV - 1);
    localparam logic [CW-1:0] CountFull = CW'(FIFO_DEPTH);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo: bit period DIV must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((1 << AW) != FIFO_DEPTH)) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e          r_state;
    state_e          w_state_next;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;
    logic            r_ready;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_next;
    logic [2:0]      r_bit;
    logic [2:0]      w_bit_next;
    logic [BW-1:0]   r_baud;
    logic [BW-1:0]   w_baud_next;
    logic            r_txd;
    logic            w_txd_next;
    logic            w_push;
    logic            w_pop;
    logic            w_tick;
`ifdef UART_TX_PARITY_EN
    logic            r_par;
`endif

    assign w_push = tx_valid && r_ready;
    assign w_tick = (r_baud == BaudLast);

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= tx_data;
        end
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_next;
            r_ready <= (w_count_next < CountFull);
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM; the line level is computed from the current state and
    // registered, so txd trails the state by one cycle for every bit alike.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud + BW'(1);
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        w_txd_next   = 1'b1;
        unique case (r_state)
            StIdle: begin
                w_baud_next = '0;
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_shift_next = r_mem[r_rptr];
                    w_bit_next   = '0;
                    w_state_next = StStart;
                end
            end
            StStart: begin
                w_txd_next = 1'b0;
                if (w_tick) begin
                    w_baud_next  = '0;
                    w_state_next = StData;
                end
            end
            StData: begin
                w_txd_next = r_shift[0];
                if (w_tick) begin
                    w_baud_next  = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    w_bit_next   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = StParity;
`else
                        w_state_next = StStop;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                w_txd_next = r_par;
                if (w_tick) begin
                    w_baud_next  = '0;
                    w_state_next = StStop;
                end
            end
`endif
            StStop: begin
                w_txd_next = 1'b1;
                if (w_tick) begin
                    w_baud_next  = '0;
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_baud_next  = '0;
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            r_state <= StIdle;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_txd   <= w_txd_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity is latched from the popped byte before the shifter consumes it.
    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            r_par <= 1'b0;
        end else if (w_pop) begin
            r_par <= ^r_mem[r_rptr];
        end
    end
`endif

    assign tx_ready   = r_ready;
    assign txd        = r_txd;
    assign fifo_count = r_count;
    assign busy       = (r_count != '0) || (r_state != StIdle);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo at DIV=10, FIFO_DEPTH=4 with a line-level UART monitor.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int unsigned CLK_HZ = 1000000;
    localparam int unsigned BAUD   = 100000;
    localparam int unsigned DEPTH  = 4;
    localparam int          DIV    = 10;
`ifdef UART_TX_PARITY_EN
    localparam int          NBITS  = 11;
`else
    localparam int          NBITS  = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int rst_epoch = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         start;
    } frame_t;

    frame_t frames[$];

    uart_tx_fifo #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .Clk         (clk),
        .reset_rtl_0 (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .txd         (txd),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge rst_n) rst_epoch++;

    // Line decoder: finds a start bit and samples each bit mid-period.
    initial begin : monitor
        frame_t f;
        int     ep;
        logic   ok;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && txd === 1'b0) begin
                f.start = cyc;
                ep      = rst_epoch;
                ok      = 1'b1;
                repeat (DIV / 2) @(negedge clk);
                if (txd !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    f.data[i] = txd;
                end
                f.par = 1'b0;
`ifdef UART_TX_PARITY_EN
                repeat (DIV) @(negedge clk);
                f.par = txd;
`endif
                repeat (DIV) @(negedge clk);
                f.stop = txd;
                if (ok && ep == rst_epoch && rst_n === 1'b1) frames.push_back(f);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic push_byte(input logic [7:0] d, output bit to);
        int t = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        to = (tx_ready !== 1'b1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, output bit to);
        int t = 0;
        while (frames.size() < n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        to = (frames.size() < n);
    endtask

    task automatic wait_idle(output bit to);
        int t = 0;
        @(negedge clk);
        while (busy !== 1'b0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        to = (busy !== 1'b0);
        repeat (DIV + 2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b expected 1", txd); end
        n_cmp++;
        if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", tx_ready); end
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++;
        if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b expected 1", tx_ready); end
        n_cmp++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: txd=%b busy=%b expected txd=1 busy=0", txd, busy);
        end
    endtask

    // Cycle-exact waveform of one frame; k counts cycles after the accepting edge.
    task automatic test_single_frame(input logic [7:0] d);
        bit   to;
        int   b;
        logic e_txd, e_busy;
        logic [2:0] e_cnt;
        frames.delete();
        push_byte(d, to);
        n_cmp++;
        if (to) begin n_fail++; $display("FAIL single_push: ready never rose, expected 1"); end
        for (int k = 0; k <= NBITS * DIV + 5; k++) begin
            @(negedge clk);
            if (k < 2 || k >= 2 + NBITS * DIV) e_txd = 1'b1;
            else begin
                b = (k - 2) / DIV;
                if (b == 0) e_txd = 1'b0;
                else if (b <= 8) e_txd = d[b-1];
                else if (b == 9 && NBITS == 11) e_txd = ^d;
                else e_txd = 1'b1;
            end
            e_busy = (k <= NBITS * DIV);
            e_cnt  = (k == 0) ? 3'd1 : 3'd0;
            n_cmp++;
            if (txd !== e_txd) begin
                n_fail++;
                $display("FAIL single_txd k=%0d: got %b expected %b", k, txd, e_txd);
            end
            n_cmp++;
            if (busy !== e_busy) begin
                n_fail++;
                $display("FAIL single_busy k=%0d: got %b expected %b", k, busy, e_busy);
            end
            n_cmp++;
            if (fifo_count !== e_cnt) begin
                n_fail++;
                $display("FAIL single_count k=%0d: got %0d expected %0d", k, fifo_count, e_cnt);
            end
        end
        n_cmp++;
        if (frames.size() != 1 || frames[0].data !== d) begin
            n_fail++;
            $display("FAIL single_decode: got %0d frames expected 1 frame of %02h", frames.size(), d);
        end
    endtask

    task automatic test_back_to_back();
        bit to, to2;
        frames.delete();
        push_byte(8'hA3, to);
        push_byte(8'h0F, to2);
        n_cmp++;
        if (to || to2) begin n_fail++; $display("FAIL b2b_push: ready timeout, expected accepts"); end
        @(negedge clk);
        n_cmp++;
        if (fifo_count !== 3'd1) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected 1", fifo_count);
        end
        wait_frames(2, to);
        n_cmp++;
        if (to) begin
            n_fail++;
            $display("FAIL b2b_frames: got %0d frames expected 2", frames.size());
        end else begin
            n_cmp++;
            if (frames[0].data !== 8'hA3 || frames[1].data !== 8'h0F) begin
                n_fail++;
                $display("FAIL b2b_data: got %02h %02h expected a3 0f", frames[0].data, frames[1].data);
            end
            n_cmp++;
            if (frames[1].start - frames[0].start != NBITS * DIV + 1) begin
                n_fail++;
                $display("FAIL b2b_gap: got %0d cycles expected %0d",
                         frames[1].start - frames[0].start, NBITS * DIV + 1);
            end
            n_cmp++;
            if (frames[0].stop !== 1'b1 || frames[1].stop !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_stop: got %b %b expected 1 1", frames[0].stop, frames[1].stop);
            end
        end
    endtask

    // Second push lands exactly in the IDLE pop cycle of the first byte.
    task automatic test_push_pop();
        bit to;
        logic [7:0] a, b;
        a = 8'($urandom);
        b = 8'($urandom);
        frames.delete();
        push_byte(a, to);
        @(negedge clk);
        n_cmp++;
        if (fifo_count !== 3'd1 || tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL pp_pre: count=%0d ready=%b expected count=1 ready=1", fifo_count, tx_ready);
        end
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fifo_count !== 3'd1) begin
            n_fail++;
            $display("FAIL pp_count: got %0d expected 1", fifo_count);
        end
        wait_frames(2, to);
        n_cmp++;
        if (to || frames[0].data !== a || frames[1].data !== b) begin
            n_fail++;
            $display("FAIL pp_data: got %0d frames expected %02h then %02h", frames.size(), a, b);
        end
    endtask

    task automatic test_fifo_full();
        bit   to;
        int   v = 1;
        int   accepts = 0;
        int   stall_at = -1;
        logic r;
        frames.delete();
        @(negedge clk);
        tx_data  = 8'd1;
        tx_valid = 1'b1;
        for (int t = 0; t < 3000 && v <= 8; t++) begin
            r = tx_ready;
            n_cmp++;
            if (fifo_count > 3'd4) begin
                n_fail++;
                $display("FAIL full_count_max: got %0d expected <= 4", fifo_count);
            end
            n_cmp++;
            if (tx_ready !== (fifo_count < 3'd4)) begin
                n_fail++;
                $display("FAIL full_ready: got %b expected %b at count %0d",
                         tx_ready, fifo_count < 3'd4, fifo_count);
            end
            if (r !== 1'b1 && stall_at < 0) stall_at = accepts;
            @(posedge clk);
            if (r === 1'b1) begin
                accepts++;
                v++;
            end
            #1;
            if (v <= 8) tx_data = 8'(v);
            else tx_valid = 1'b0;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        n_cmp++;
        if (v <= 8) begin n_fail++; $display("FAIL full_accepts: got %0d expected 8", accepts); end
        n_cmp++;
        if (stall_at != 5) begin n_fail++; $display("FAIL full_stall: got %0d expected 5", stall_at); end
        wait_frames(8, to);
        n_cmp++;
        if (to) begin
            n_fail++;
            $display("FAIL full_frames: got %0d expected 8", frames.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (frames[i].data !== 8'(i + 1)) begin
                    n_fail++;
                    $display("FAIL full_order[%0d]: got %02h expected %02h", i, frames[i].data, i + 1);
                end
            end
        end
    endtask

    task automatic test_random();
        bit         to;
        logic [7:0] d;
        logic [7:0] exp_q[$];
        frames.delete();
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push_byte(d, to);
            n_cmp++;
            if (to) begin n_fail++; $display("FAIL rand_push[%0d]: ready timeout", i); end
            exp_q.push_back(d);
        end
        wait_frames(16, to);
        n_cmp++;
        if (to) begin
            n_fail++;
            $display("FAIL rand_frames: got %0d expected 16", frames.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if (frames[i].data !== exp_q[i] || frames[i].stop !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand_frame[%0d]: got %02h stop %b expected %02h stop 1",
                             i, frames[i].data, frames[i].stop, exp_q[i]);
                end
`ifdef UART_TX_PARITY_EN
                n_cmp++;
                if (frames[i].par !== ^exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand_par[%0d]: got %b expected %b", i, frames[i].par, ^exp_q[i]);
                end
`endif
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        bit to;
        frames.delete();
        push_byte(8'h07, to);
        wait_frames(1, to);
        push_byte(8'h03, to);
        wait_frames(2, to);
        n_cmp++;
        if (to) begin
            n_fail++;
            $display("FAIL par_frames: got %0d expected 2", frames.size());
        end else begin
            n_cmp++;
            if (frames[0].par !== 1'b1) begin n_fail++; $display("FAIL par_07: got %b expected 1", frames[0].par); end
            n_cmp++;
            if (frames[1].par !== 1'b0) begin n_fail++; $display("FAIL par_03: got %b expected 0", frames[1].par); end
        end
    endtask
`endif

    task automatic test_reset_midframe();
        bit to;
        int lows = 0;
        frames.delete();
        push_byte(8'hFF, to);
        push_byte(8'h3C, to);
        // Now just past accept edge E+1; k=47 sits mid data bit 3.
        repeat (47) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL mid_txd_async: got %b expected 1", txd); end
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_async: got %b expected 0", busy); end
        n_cmp++;
        if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL mid_count_async: got %0d expected 0", fifo_count); end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (15 * DIV) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        n_cmp++;
        if (lows != 0) begin n_fail++; $display("FAIL mid_residual: got %0d low cycles expected 0", lows); end
        n_cmp++;
        if (fifo_count !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after: count=%0d busy=%b expected 0 0", fifo_count, busy);
        end
        n_cmp++;
        if (frames.size() != 0) begin n_fail++; $display("FAIL mid_frames: got %0d expected 0", frames.size()); end
    endtask

    initial begin : main
        bit to;
        test_reset();
        test_single_frame(8'h55);
        wait_idle(to);
        test_back_to_back();
        wait_idle(to);
        test_push_pop();
        wait_idle(to);
        test_fifo_full();
        wait_idle(to);
        test_random();
        wait_idle(to);
`ifdef UART_TX_PARITY_EN
        test_parity();
        wait_idle(to);
`endif
        test_reset_midframe();
        wait_idle(to);
        n_cmp++;
        if (to) begin n_fail++; $display("FAIL final_idle: busy=%b expected 0", busy); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Fabric-side UART transmitter that lets game logic send bytes (score, line-clear events, debug) to the host terminal without going through MicroBlaze. Bytes are pushed through a valid/ready interface into an internal FIFO and serialized 8N1, LSB first, on a dedicated TX pin. It runs on the 100 MHz board clock and is the transmit counterpart of the fabric's existing receive path.

Parameters:
CLK_HZ, 100000000, input clock frequency in Hz
BAUD, 115200, line rate; bit period DIV = round(CLK_HZ/BAUD), computed as (CLK_HZ + BAUD/2)/BAUD; DIV must be >= 2
FIFO_DEPTH, 16, byte entries; power of two, >= 2

Ports:
Clk  input  1  system clock
reset_rtl_0  input  1  asynchronous active-low reset
tx_data  input  8  byte to send
tx_valid  input  1  tx_data valid
tx_ready  output  1  FIFO can accept a byte
txd  output  1  serial line; idle high
busy  output  1  high while FIFO is non-empty or a frame is in flight
fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the frame being shifted

Behaviour:
- Reset (reset_rtl_0 low, asynchronous): txd=1, tx_ready=0 during reset, busy=0, fifo_count=0; FIFO pointers and shifter cleared; FSM=IDLE. Reset asserted mid-frame aborts the frame immediately, with txd forced to 1.
- After reset release, tx_ready = (fifo_count < FIFO_DEPTH), registered.
- Push: a byte is accepted on the rising edge of Clk where tx_valid && tx_ready. tx_valid asserted while tx_ready=0 is ignored with no side effect. The source holds data until accepted.
- FIFO: circular, read/write pointers wrap modulo FIFO_DEPTH. A push and a pop in the same cycle leave count unchanged; a push while full is impossible (ready=0). A pop while empty does not occur.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if count>0, pop the head byte into the shifter and go to START on the next cycle. Otherwise hold txd=1.
  - START: txd=0 for DIV cycles.
  - DATA: txd=shift[0] for DIV cycles per bit; shift right after each bit; 8 bits; bit counter 0..7.
  - STOP: txd=1 for DIV cycles, then return to IDLE. Back-to-back frames therefore have exactly 1 extra idle cycle (the IDLE pop cycle) between the stop and the next start.
- Baud counter counts 0..DIV-1; it resets to 0 on every state entry and on every bit boundary.
- Latency: a push into an empty idle FIFO drives txd low 2 cycles after the accepting edge (1 cycle to enqueue, 1 cycle for the IDLE pop).
- busy = (count != 0) || (state != IDLE); it is combinational from registered state.
- txd is driven from a flop (glitch-free).

Optional Feature:
UART_TX_PARITY_EN. When defined, a PARITY state sits between DATA and STOP and drives even parity (XOR of the 8 data bits) for DIV cycles, giving 8E1 frames of 11 bit periods. When undefined, there is no PARITY state, frames are 8N1 with 10 bit periods, and no parity logic is synthesized.

Test Plan:
- CLK_HZ=1000000, BAUD=100000 (DIV=10); push 0x55 once -> txd low from cycle 2 for 10 cycles, then 1,0,1,0,1,0,1,0 for 10 cycles each, then high for 10 cycles; busy drops on the cycle after STOP ends.
- Push 0xA3, 0x0F on consecutive cycles -> two frames decoded by the bench UART monitor as 0xA3 then 0x0F; exactly 1 idle cycle between the stop of the first and the start of the second.
- FIFO_DEPTH=4: hold tx_valid high with values 1..8 -> tx_ready falls after 5 accepts (1 popped + 4 queued); all 8 bytes eventually transmitted in order 1..8; fifo_count never exceeds 4.
- Simultaneous push and pop in the IDLE pop cycle with count=1 -> fifo_count stays 1; the next frame carries the correct byte.
- Assert reset_rtl_0 low during DATA bit 3 of 0xFF -> txd=1 and busy=0 asynchronously; after release, fifo_count=0 and no residual frame is sent.
- With UART_TX_PARITY_EN: send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; each frame lasts 110 cycles at DIV=10.
